axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Multi-client AXI read arbiter: per-client request FSMs share one AR channel, R beats routed by rid.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed lowest-index priority.
module axi_rd_arbiter #(
    parameter int unsigned NPORT     = 2,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ID_W      = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NPORT-1:0]              req_valid,
    output logic [NPORT-1:0]              req_ready,
    input  logic [NPORT-1:0]              req_cached,
    input  logic [NPORT*32-1:0]           req_addr,
    output logic [NPORT-1:0]              rsp_valid,
    output logic [NPORT*BURST_LEN*32-1:0] rsp_block,
    output logic [ID_W-1:0]               arid,
    output logic [31:0]                   araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [ID_W-1:0]               rid,
    input  logic [31:0]                   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);
    localparam int unsigned BLK_W = BURST_LEN * 32;
    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned OFF_W = $clog2(BURST_LEN) + 2;
    localparam int unsigned PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [31:0] BLK_MASK = ~((32'd1 << OFF_W) - 32'd1);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA, ST_DONE} state_e;

    state_e                      state_q [NPORT];
    state_e                      state_d [NPORT];
    logic [NPORT-1:0][31:0]      addr_q, addr_d;
    logic [NPORT-1:0]            cached_q, cached_d;
    logic [NPORT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NPORT-1:0][BLK_W-1:0] blk_q, blk_d;
    logic [NPORT-1:0]            req_ready_q, req_ready_d;
    logic [NPORT-1:0]            rsp_valid_q, rsp_valid_d;
    logic                        rready_q;
    logic                        arvalid_q, arvalid_d;
    logic [ID_W-1:0]             arid_q, arid_d;
    logic [31:0]                 araddr_q, araddr_d;
    logic [7:0]                  arlen_q, arlen_d;
    logic                        sel_found;
    logic [PTR_W-1:0]            sel_idx;
    logic                        ar_fire;
    logic                        r_fire;
    logic                        unused_rresp;
`ifdef ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]            ptr_q, ptr_d;
`endif

    assign unused_rresp = ^rresp;
    assign ar_fire = arvalid_q & arready;
    assign r_fire  = rvalid & rready_q & (32'(rid) < NPORT);

    // Grant selection among PEND clients
    always_comb begin : arb_select
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (!sel_found && state_q[(32'(ptr_q) + k) % NPORT] == ST_PEND) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'((32'(ptr_q) + k) % NPORT);
            end
        end
`else
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (!sel_found && state_q[k] == ST_PEND) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(k);
            end
        end
`endif
    end

    always_comb begin : next_state
        arvalid_d   = arvalid_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        addr_d      = addr_q;
        cached_d    = cached_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        for (int unsigned i = 0; i < NPORT; i++) state_d[i] = state_q[i];
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d = ptr_q;
        if (ar_fire) ptr_d = PTR_W'((32'(arid_q) + 1) % NPORT);
`endif

        // AR payload frozen while arvalid is high; new grant only once the channel is free
        if (ar_fire) arvalid_d = 1'b0;
        if (!arvalid_q && sel_found) begin
            arvalid_d = 1'b1;
            arid_d    = ID_W'(sel_idx);
            araddr_d  = cached_q[sel_idx] ? (addr_q[sel_idx] & BLK_MASK) : addr_q[sel_idx];
            arlen_d   = cached_q[sel_idx] ? 8'(BURST_LEN - 1) : 8'd0;
        end

        for (int unsigned i = 0; i < NPORT; i++) begin
            case (state_q[i])
                ST_IDLE: if (req_valid[i]) begin
                    state_d[i]  = ST_PEND;
                    addr_d[i]   = req_addr[i*32 +: 32];
                    cached_d[i] = req_cached[i];
                    cnt_d[i]    = '0;
                    blk_d[i]    = '0;
                end
                ST_PEND: if (ar_fire && arid_q == ID_W'(i)) state_d[i] = ST_DATA;
                ST_DATA: if (r_fire && rid == ID_W'(i) && cnt_q[i] < CNT_W'(BURST_LEN)) begin
                    for (int unsigned w = 0; w < BURST_LEN; w++) begin
                        if (cnt_q[i] == CNT_W'(w)) blk_d[i][w*32 +: 32] = rdata;
                    end
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    if (rlast) state_d[i] = ST_DONE;
                end
                ST_DONE: state_d[i] = ST_IDLE;
                default: state_d[i] = ST_IDLE;
            endcase
            req_ready_d[i] = (state_d[i] == ST_IDLE);
            rsp_valid_d[i] = (state_d[i] == ST_DONE);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < NPORT; i++) state_q[i] <= ST_IDLE;
            addr_q      <= '0;
            cached_q    <= '0;
            cnt_q       <= '0;
            blk_q       <= '0;
            req_ready_q <= '1;
            rsp_valid_q <= '0;
            rready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NPORT; i++) state_q[i] <= state_d[i];
            addr_q      <= addr_d;
            cached_q    <= cached_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rready_q    <= 1'b1;
            arvalid_q   <= arvalid_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_block = blk_q;
    assign arvalid   = arvalid_q;
    assign arid      = arid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = 3'd2;
    assign arburst   = 2'b01;
    assign rready    = rready_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed requests push expected AR/response records,
// a negedge monitor pops and compares on every AR handshake and rsp_valid pulse.
module tb_axi_rd_arbiter;
    localparam int unsigned NPORT = 2;
    localparam int unsigned BL    = 4;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned BLK_W = BL * 32;

    typedef struct {
        int          id;
        logic [31:0] addr;
        int          len;
    } ar_t;

    typedef struct {
        int               port;
        logic [BLK_W-1:0] blk;
    } rsp_t;

    logic                    aclk, aresetn;
    logic [NPORT-1:0]        req_valid, req_ready, req_cached, rsp_valid;
    logic [NPORT*32-1:0]     req_addr;
    logic [NPORT*BLK_W-1:0]  rsp_block;
    logic [ID_W-1:0]         arid, rid;
    logic [31:0]             araddr, rdata;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst, rresp;
    logic                    arvalid, arready, rlast, rvalid, rready;

    int   checks = 0;
    int   errors = 0;
    ar_t  ar_q[$];
    rsp_t rsp_q[$];
    ar_t  ear;
    rsp_t ers;

    axi_rd_arbiter #(.NPORT(NPORT), .BURST_LEN(BL), .ID_W(ID_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_cached(req_cached), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_block(rsp_block),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push_ar(input int id, input logic [31:0] a, input int len);
        ar_t e;
        e.id = id; e.addr = a; e.len = len;
        ar_q.push_back(e);
    endtask

    task automatic push_rsp(input int p, input logic [BLK_W-1:0] b);
        rsp_t e;
        e.port = p; e.blk = b;
        rsp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] m, input logic [1:0] c, input logic [63:0] a);
        int n = 0;
        while ((req_ready & m) != m && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready %b required %b", req_ready, m);
        end
        req_valid  = m;
        req_cached = c;
        req_addr   = a;
        tick();
        req_valid  = '0;
    endtask

    task automatic beat(input int id, input logic [31:0] d, input logic l, input logic [1:0] r);
        rid    = ID_W'(id);
        rdata  = d;
        rlast  = l;
        rresp  = r;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    // Monitor: every AR handshake and response pulse must match the next queued expectation
    always @(negedge aclk) begin
        if (aresetn) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected: arid %0d araddr %h with no expectation", arid, araddr);
                end else begin
                    ear = ar_q.pop_front();
                    chk("ar_fields", BLK_W'({arid, araddr, arlen, arsize, arburst}),
                        BLK_W'({4'(ear.id), ear.addr, 8'(ear.len), 3'd2, 2'b01}));
                end
            end
            for (int i = 0; i < int'(NPORT); i++) begin
                if (rsp_valid[i]) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: rsp_valid[%0d] with no expectation", i);
                    end else begin
                        ers = rsp_q.pop_front();
                        chk("rsp_port", BLK_W'(i), BLK_W'(ers.port));
                        chk("rsp_block", rsp_block[i*BLK_W +: BLK_W], ers.blk);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; arready = 1'b1; rvalid = 1'b0; rlast = 1'b0;
        rid = '0; rdata = '0; rresp = '0;
        req_valid = '0; req_cached = '0; req_addr = '0;
        repeat (3) tick();
        chk("rst_rready_low", BLK_W'(rready), BLK_W'(0));
        chk("rst_arvalid", BLK_W'(arvalid), BLK_W'(0));
        aresetn = 1'b1;
        tick();
        chk("rst_req_ready", BLK_W'(req_ready), BLK_W'(2'b11));
        chk("rst_rsp_valid", BLK_W'(rsp_valid), BLK_W'(0));
        chk("rst_rsp_block", rsp_block[BLK_W-1:0], '0);
        chk("rst_rready_high", BLK_W'(rready), BLK_W'(1));

        // Cached refill, client 0
        push_ar(0, 32'h1C00_0010, 3);
        issue(2'b01, 2'b01, {32'h0, 32'h1C00_0014});
        repeat (4) tick();
        push_rsp(0, {32'hD, 32'hC, 32'hB, 32'hA});
        beat(0, 32'hA, 1'b0, 2'b00);
        beat(0, 32'hB, 1'b0, 2'b10);
        beat(0, 32'hC, 1'b0, 2'b00);
        beat(0, 32'hD, 1'b1, 2'b00);
        repeat (3) tick();

        // Uncached single word, client 1
        push_ar(1, 32'hBFAF_8004, 0);
        issue(2'b10, 2'b00, {32'hBFAF_8004, 32'h0});
        repeat (4) tick();
        push_rsp(1, BLK_W'(32'h55));
        beat(1, 32'h55, 1'b1, 2'b00);
        repeat (3) tick();

        // Both pending with AR stalled, then interleaved R beats
        arready = 1'b0;
        push_ar(0, 32'h1000_0000, 3);
        push_ar(1, 32'h2000_0030, 3);
        issue(2'b11, 2'b11, {32'h2000_003C, 32'h1000_0008});
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_arvalid", BLK_W'(arvalid), BLK_W'(1));
            chk("stall_araddr", BLK_W'(araddr), BLK_W'(32'h1000_0000));
            chk("stall_arid", BLK_W'(arid), BLK_W'(0));
            tick();
        end
        arready = 1'b1;
        repeat (5) tick();
        push_rsp(1, {32'h203, 32'h202, 32'h201, 32'h200});
        push_rsp(0, {32'h103, 32'h102, 32'h101, 32'h100});
        beat(1, 32'h200, 1'b0, 2'b00);
        beat(0, 32'h100, 1'b0, 2'b00);
        beat(3, 32'hDEAD, 1'b1, 2'b00);
        beat(1, 32'h201, 1'b0, 2'b00);
        beat(0, 32'h101, 1'b0, 2'b11);
        beat(1, 32'h202, 1'b0, 2'b00);
        beat(1, 32'h203, 1'b1, 2'b00);
        beat(0, 32'h102, 1'b0, 2'b00);
        beat(0, 32'h103, 1'b1, 2'b00);
        repeat (3) tick();

        // Cached refill ended early by rlast; upper words stay cleared
        push_ar(0, 32'h0000_0100, 3);
        issue(2'b01, 2'b01, {32'h0, 32'h0000_0104});
        repeat (4) tick();
        push_rsp(0, {32'h0, 32'h0, 32'h22, 32'h11});
        beat(0, 32'h11, 1'b0, 2'b00);
        beat(0, 32'h22, 1'b1, 2'b00);
        repeat (3) tick();

        // Both pending after a client-0-only grant: order depends on arbitration mode
`ifdef ARB_ROUND_ROBIN_EN
        push_ar(1, 32'h0000_0088, 0);
        push_ar(0, 32'h0000_0044, 0);
`else
        push_ar(0, 32'h0000_0044, 0);
        push_ar(1, 32'h0000_0088, 0);
`endif
        issue(2'b11, 2'b00, {32'h0000_0088, 32'h0000_0044});
        repeat (6) tick();
        push_rsp(0, BLK_W'(32'h44A));
        push_rsp(1, BLK_W'(32'h88B));
        beat(0, 32'h44A, 1'b1, 2'b00);
        beat(1, 32'h88B, 1'b1, 2'b00);
        repeat (3) tick();

        // Reset mid-burst, then stale beats for the abandoned transfer
        push_ar(0, 32'h0000_0300, 3);
        issue(2'b01, 2'b01, {32'h0, 32'h0000_030C});
        repeat (4) tick();
        beat(0, 32'h1, 1'b0, 2'b00);
        beat(0, 32'h2, 1'b0, 2'b00);
        aresetn = 1'b0;
        tick();
        chk("midrst_rready", BLK_W'(rready), BLK_W'(0));
        chk("midrst_arvalid", BLK_W'(arvalid), BLK_W'(0));
        chk("midrst_rsp_valid", BLK_W'(rsp_valid), BLK_W'(0));
        aresetn = 1'b1;
        tick();
        chk("postrst_req_ready", BLK_W'(req_ready), BLK_W'(2'b11));
        chk("postrst_rsp_block", BLK_W'(rsp_block[BLK_W-1:0] | rsp_block[2*BLK_W-1:BLK_W]), '0);
        beat(0, 32'h3, 1'b0, 2'b00);
        beat(0, 32'h4, 1'b1, 2'b00);
        repeat (3) tick();
        chk("stale_req_ready", BLK_W'(req_ready), BLK_W'(2'b11));
        chk("stale_rsp_block", rsp_block[BLK_W-1:0], '0);

        chk("ar_queue_empty", BLK_W'(ar_q.size()), BLK_W'(0));
        chk("rsp_queue_empty", BLK_W'(rsp_q.size()), BLK_W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
